// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo types, default widths and tag helper
package tomasulo_pkg;

   localparam int NULL_TAG   = 0;
   localparam int DEF_TAG_W  = 4;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_OP_W   = 2;

   typedef struct packed {
      logic                  busy;
      logic [DEF_OP_W-1:0]   op;
      logic [DEF_TAG_W-1:0]  q1;
      logic [DEF_DATA_W-1:0] v1;
      logic [DEF_TAG_W-1:0]  q2;
      logic [DEF_DATA_W-1:0] v2;
   } rs_entry_t;

   // Station id sits above the entry index; callers truncate to their TAG_W.
   function automatic int unsigned tag_of(input int unsigned station,
                                          input int unsigned idx,
                                          input int unsigned idx_w);
      return (station << idx_w) | idx;
   endfunction

endpackage

// File: rtl/rs_station_param_if.sv
// rtl/rs_station_param_if.sv - issue, CDB and dispatch bundle of the reservation station
interface rs_station_param_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 2,
   parameter int TAG_W  = 4
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [TAG_W-1:0]  in_q1;
   logic [TAG_W-1:0]  in_q2;
   logic [DATA_W-1:0] in_v1;
   logic [DATA_W-1:0] in_v2;
   logic [TAG_W-1:0]  alloc_tag;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              out_valid;
   logic              out_ready;
   logic [OP_W-1:0]   out_op;
   logic [DATA_W-1:0] out_v1;
   logic [DATA_W-1:0] out_v2;
   logic [TAG_W-1:0]  out_tag;
   logic [IDX_W:0]    occupancy;

   modport slave (
      input  flush, in_valid, in_op, in_q1, in_q2, in_v1, in_v2,
      input  cdb_valid, cdb_tag, cdb_data, out_ready,
      output in_ready, alloc_tag, out_valid, out_op, out_v1, out_v2, out_tag, occupancy
   );

   modport master (
      output flush, in_valid, in_op, in_q1, in_q2, in_v1, in_v2,
      output cdb_valid, cdb_tag, cdb_data, out_ready,
      input  in_ready, alloc_tag, out_valid, out_op, out_v1, out_v2, out_tag, occupancy
   );

endinterface

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - older-than bit matrix granting the oldest requesting entry
module rs_age_matrix #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             i_flush,
   input  logic [DEPTH-1:0] i_alloc,
   input  logic [DEPTH-1:0] i_free,
   input  logic [DEPTH-1:0] i_req,
   output logic [DEPTH-1:0] o_grant
);

   // r_older[i][j] set means entry i is older than entry j
   logic [DEPTH-1:0] r_older [DEPTH];
   logic             w_blocked;

   // A new entry is younger than every slot; stale bits of free slots are never requested.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (i_alloc[j])
                  r_older[i][j] <= (i != j);
               else if (i_alloc[i] || i_free[i] || i_free[j])
                  r_older[i][j] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      o_grant   = '0;
      w_blocked = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (i_req[j] && r_older[j][i]) w_blocked = 1'b1;
         end
         o_grant[i] = i_req[i] && !w_blocked;
      end
   end

endmodule

// File: rtl/rs_station_param.sv
// rtl/rs_station_param.sv - reservation station: entry storage, CDB snoop, allocation and dispatch
module rs_station_param
   import tomasulo_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int OP_W       = DEF_OP_W,
   parameter int TAG_W      = DEF_TAG_W,
   parameter int STATION_ID = 1
) (
   input logic               clk,
   input logic               nRST,
   rs_station_param_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W:0] OCC_ONE = 1;

   typedef struct packed {
      logic              busy;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  q1;
      logic [DATA_W-1:0] v1;
      logic [TAG_W-1:0]  q2;
      logic [DATA_W-1:0] v2;
   } entry_t;

   entry_t           r_entry [DEPTH];
   logic [IDX_W:0]   r_occ;

   entry_t           w_new;
   logic [IDX_W-1:0] w_free_idx;
   logic [IDX_W-1:0] w_sel_idx;
   logic             w_any_free;
   logic             w_cdb_live;
   logic             w_issue;
   logic             w_disp;
   logic [DEPTH-1:0] w_ready;
   logic [DEPTH-1:0] w_grant;
   logic [DEPTH-1:0] w_alloc_oh;
   logic [DEPTH-1:0] w_free_oh;
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;

   assign w_cdb_live = bus.cdb_valid && (bus.cdb_tag != TAG_W'(NULL_TAG));

   always_comb begin
      w_free_idx = '0;
      w_any_free = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_entry[i].busy) begin
            w_free_idx = IDX_W'(i);
            w_any_free = 1'b1;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      w_hit1  = '0;
      w_hit2  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i] = r_entry[i].busy && (r_entry[i].q1 == TAG_W'(NULL_TAG))
                                      && (r_entry[i].q2 == TAG_W'(NULL_TAG));
         w_hit1[i]  = r_entry[i].busy && w_cdb_live && (r_entry[i].q1 == bus.cdb_tag);
         w_hit2[i]  = r_entry[i].busy && w_cdb_live && (r_entry[i].q2 == bus.cdb_tag);
      end
   end

   // Operands broadcast in the issue cycle are captured straight into the new entry.
   always_comb begin
      w_new      = '0;
      w_new.busy = 1'b1;
      w_new.op   = bus.in_op;
      w_new.q1   = bus.in_q1;
      w_new.v1   = bus.in_v1;
      w_new.q2   = bus.in_q2;
      w_new.v2   = bus.in_v2;
      if (w_cdb_live && bus.in_q1 == bus.cdb_tag) begin
         w_new.q1 = '0;
         w_new.v1 = bus.cdb_data;
      end
      if (w_cdb_live && bus.in_q2 == bus.cdb_tag) begin
         w_new.q2 = '0;
         w_new.v2 = bus.cdb_data;
      end
   end

   assign w_issue    = bus.in_valid && w_any_free && !bus.flush;
   assign w_disp     = bus.out_valid && bus.out_ready && !bus.flush;
   assign w_alloc_oh = w_issue ? (DEPTH'(1) << w_free_idx) : '0;
   assign w_free_oh  = w_disp ? w_grant : '0;

   rs_age_matrix #(.DEPTH(DEPTH)) u_age (
      .clk     (clk),
      .nRST    (nRST),
      .i_flush (bus.flush),
      .i_alloc (w_alloc_oh),
      .i_free  (w_free_oh),
      .i_req   (w_ready),
      .o_grant (w_grant)
   );

   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_grant[i]) w_sel_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
         r_occ <= '0;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) r_entry[i].busy <= 1'b0;
         r_occ <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_hit1[i]) begin
               r_entry[i].q1 <= '0;
               r_entry[i].v1 <= bus.cdb_data;
            end
            if (w_hit2[i]) begin
               r_entry[i].q2 <= '0;
               r_entry[i].v2 <= bus.cdb_data;
            end
            if (w_disp && w_grant[i]) r_entry[i].busy <= 1'b0;
            if (w_issue && w_free_idx == IDX_W'(i)) r_entry[i] <= w_new;
         end
         if (w_issue && !w_disp)
            r_occ <= r_occ + OCC_ONE;
         else if (!w_issue && w_disp)
            r_occ <= r_occ - OCC_ONE;
      end
   end

   assign bus.in_ready  = w_any_free;
   assign bus.alloc_tag = TAG_W'(tag_of(STATION_ID, 32'(w_free_idx), IDX_W));
   assign bus.out_valid = |w_ready;
   assign bus.out_op    = r_entry[w_sel_idx].op;
   assign bus.out_v1    = r_entry[w_sel_idx].v1;
   assign bus.out_v2    = r_entry[w_sel_idx].v2;
   assign bus.out_tag   = TAG_W'(tag_of(STATION_ID, 32'(w_sel_idx), IDX_W));
   assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_rs_station_param.sv
// tb/tb_rs_station_param.sv - directed scoreboard bench for rs_station_param
module tb_rs_station_param;
   import tomasulo_pkg::*;

   localparam int DEPTH      = 4;
   localparam int DATA_W     = 32;
   localparam int OP_W       = 2;
   localparam int TAG_W      = 4;
   localparam int STATION_ID = 1;
   localparam int IDX_W      = 2;

   typedef struct {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] v1;
      logic [DATA_W-1:0] v2;
      logic [TAG_W-1:0]  tag;
   } exp_t;

   logic clk  = 1'b0;
   logic nRST = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;
   exp_t sb[$];
   exp_t m_e;

   always #5 clk = ~clk;

   rs_station_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

   rs_station_param #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .STATION_ID(STATION_ID)
   ) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   function automatic logic [TAG_W-1:0] tg(input int idx);
      return TAG_W'((STATION_ID << IDX_W) + idx);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] q1,
                        input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] q2,
                        input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] exp_tag);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_q1    = q1;
      bus.in_v1    = v1;
      bus.in_q2    = q2;
      bus.in_v2    = v2;
      @(negedge clk);
      chk("issue_in_ready", 32'(bus.in_ready), 1);
      chk("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tag));
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic push(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                       input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] tag);
      exp_t e;
      e.op = op; e.v1 = v1; e.v2 = v2; e.tag = tag;
      sb.push_back(e);
   endtask

   // Every accepted dispatch must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (nRST && bus.out_valid && bus.out_ready && !bus.flush) begin
         if (sb.size() == 0) begin
            chk("unexpected_dispatch", 32'(bus.out_tag), 32'hFFFF_FFFF);
         end else begin
            m_e = sb.pop_front();
            chk("disp_op", 32'(bus.out_op), 32'(m_e.op));
            chk("disp_v1", bus.out_v1, m_e.v1);
            chk("disp_v2", bus.out_v2, m_e.v2);
            chk("disp_tag", 32'(bus.out_tag), 32'(m_e.tag));
         end
      end
   end

   initial begin
      bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_q1 = 0; bus.in_q2 = 0;
      bus.in_v1 = 0; bus.in_v2 = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
      bus.out_ready = 0;

      step();
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_occupancy", 32'(bus.occupancy), 0);
      nRST = 1'b1;
      step();

      // basic issue and dispatch one cycle later
      bus.out_ready = 1'b1;
      push(2'd1, 32'd5, 32'd7, tg(0));
      issue(2'd1, 4'd0, 32'd5, 4'd0, 32'd7, tg(0));
      @(negedge clk);
      chk("t1_out_valid", 32'(bus.out_valid), 1);
      chk("t1_occ_busy", 32'(bus.occupancy), 1);
      step();
      @(negedge clk);
      chk("t1_occ_after", 32'(bus.occupancy), 0);
      chk("t1_out_valid_after", 32'(bus.out_valid), 0);
      step();

      // operand waits on tag 9, released by a later broadcast
      issue(2'd2, 4'd9, 32'd0, 4'd0, 32'h11, tg(0));
      @(negedge clk);
      chk("t2_wait0", 32'(bus.out_valid), 0);
      step();
      @(negedge clk);
      chk("t2_wait1", 32'(bus.out_valid), 0);
      step();
      push(2'd2, 32'hAA, 32'h11, tg(0));
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'hAA;
      @(negedge clk);
      chk("t2_bcast_cycle", 32'(bus.out_valid), 0);
      step();
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      chk("t2_after_bcast", 32'(bus.out_valid), 1);
      step();

      // issue-time CDB bypass
      push(2'd3, 32'h44, 32'h33, tg(0));
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'h33;
      issue(2'd3, 4'd0, 32'h44, 4'd9, 32'h0, tg(0));
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      chk("t3_bypass_ready", 32'(bus.out_valid), 1);
      step();
      @(negedge clk);
      chk("t3_occ", 32'(bus.occupancy), 0);
      step();

      // fill every entry, then release all in issue order
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         issue(OP_W'(i), 4'd9, 32'd0, 4'd0, 32'(i + 16), tg(i));
      bus.in_valid = 1'b1; bus.in_q1 = 0; bus.in_q2 = 0; bus.in_op = 2'd3;
      @(negedge clk);
      chk("t4_full_in_ready", 32'(bus.in_ready), 0);
      chk("t4_full_occ", 32'(bus.occupancy), 4);
      chk("t4_full_out_valid", 32'(bus.out_valid), 0);
      step();
      bus.in_valid = 1'b0;
      chk("t4_occ_held", 32'(bus.occupancy), 4);
      for (int i = 0; i < DEPTH; i++) push(OP_W'(i), 32'h55, 32'(i + 16), tg(i));
      bus.out_ready = 1'b1;
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'h55;
      @(negedge clk);
      chk("t4_bcast_cycle", 32'(bus.out_valid), 0);
      step();
      bus.cdb_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) step();
      @(negedge clk);
      chk("t4_drained_occ", 32'(bus.occupancy), 0);
      chk("t4_drained_sb", 32'(sb.size()), 0);
      step();

      // younger ready entry shown until the older one becomes ready
      bus.out_ready = 1'b0;
      issue(2'd1, 4'd9, 32'd0, 4'd0, 32'h0A, tg(0));
      issue(2'd2, 4'd0, 32'hB1, 4'd0, 32'hB2, tg(1));
      @(negedge clk);
      chk("t5_b_shown", 32'(bus.out_tag), 32'(tg(1)));
      step();
      @(negedge clk);
      chk("t5_b_stable", 32'(bus.out_tag), 32'(tg(1)));
      step();
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'hA1;
      @(negedge clk);
      chk("t5_b_during_bcast", 32'(bus.out_tag), 32'(tg(1)));
      step();
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      chk("t5_a_older", 32'(bus.out_tag), 32'(tg(0)));
      step();
      push(2'd1, 32'hA1, 32'h0A, tg(0));
      push(2'd2, 32'hB1, 32'hB2, tg(1));
      bus.out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("t5_occ", 32'(bus.occupancy), 0);
      step();

      // flush overrides issue and dispatch
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(2'd0, 4'd0, 32'(i), 4'd0, 32'(i), tg(i));
      @(negedge clk);
      chk("t6_occ3", 32'(bus.occupancy), 3);
      step();
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("t6_flush_out_valid", 32'(bus.out_valid), 1);
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      chk("t6_post_occ", 32'(bus.occupancy), 0);
      chk("t6_post_in_ready", 32'(bus.in_ready), 1);
      chk("t6_post_out_valid", 32'(bus.out_valid), 0);
      step();

      // asynchronous reset mid-stream
      issue(2'd1, 4'd0, 32'd1, 4'd0, 32'd2, tg(0));
      @(negedge clk);
      chk("t7_pre_rst_valid", 32'(bus.out_valid), 1);
      #2;
      nRST = 1'b0;
      #1;
      chk("t7_rst_out_valid", 32'(bus.out_valid), 0);
      chk("t7_rst_occ", 32'(bus.occupancy), 0);
      chk("t7_rst_in_ready", 32'(bus.in_ready), 1);
      step();
      nRST = 1'b1;
      @(negedge clk);
      chk("t7_after_rst_valid", 32'(bus.out_valid), 0);
      chk("final_sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
